// File: rtl/mac_pkg.sv
// Shared widths, controller state encoding and operand sign-extension for the
// sequenced MAC accumulator.
package mac_pkg;
  localparam int PROD_W  = 32;
  localparam int ACC_W   = 36;
  localparam int SLICE_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [ACC_W-1:0] sext(input logic [PROD_W-1:0] x);
    return {{(ACC_W-PROD_W){x[PROD_W-1]}}, x};
  endfunction
endpackage

// File: rtl/acc_slice_add.sv
// Combinational W-bit Kogge-Stone slice adder; exposes the carry into the MSB
// so the caller can derive signed overflow on the top slice.
module acc_slice_add #(
  parameter int W = 6
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         c_msb_o
);
  logic [W-1:0] p, g, gp, pp, gn, pn, c;

  // cin is folded into bit 0's generate so the prefix tree yields carries directly
  always_comb begin
    p     = a_i ^ b_i;
    g     = a_i & b_i;
    gp    = g;
    gp[0] = g[0] | (p[0] & cin_i);
    pp    = p;
    gn    = gp;
    pn    = pp;
    for (int d = 1; d < W; d = d * 2) begin
      gn = gp;
      pn = pp;
      for (int i = d; i < W; i++) begin
        gn[i] = gp[i] | (pp[i] & gp[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      gp = gn;
      pp = pn;
    end
    c       = {gp[W-2:0], cin_i};
    sum_o   = p ^ c;
    cout_o  = gp[W-1];
    c_msb_o = c[W-1];
  end
endmodule

// File: rtl/mac_acc_seq.sv
// Sequenced accumulator: one narrow slice adder is reused over NSLICE cycles,
// with a registered carry between slices; the result commits as ADD finishes.
module mac_acc_seq
  import mac_pkg::*;
#(
  parameter int PROD_W  = mac_pkg::PROD_W,
  parameter int ACC_W   = mac_pkg::ACC_W,
  parameter int SLICE_W = mac_pkg::SLICE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PROD_W-1:0] in_data_i,
  input  logic              in_clear_i,
  output logic              out_valid_o,
  output logic [ACC_W-1:0]  out_acc_o,
  output logic              busy_o,
  output logic              ovf_o
);
  localparam int NSLICE = ACC_W / SLICE_W;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_e                          state_q, state_d;
  logic [NSLICE-1:0][SLICE_W-1:0]  opd_q, opd_d;
  logic [NSLICE-1:0][SLICE_W-1:0]  wrk_q, wrk_d;
  logic [KW-1:0]                   k_q, k_d;
  logic                            cy_q, cy_d;
  logic                            clr_q, clr_d;
  logic [ACC_W-1:0]                acc_q, acc_d;
  logic                            ovf_q, ovf_d;

  logic [SLICE_W-1:0] sum_s;
  logic               cout_s, cmsb_s;

  acc_slice_add #(.W(SLICE_W)) u_add (
    .a_i     (opd_q[k_q]),
    .b_i     (wrk_q[k_q]),
    .cin_i   (cy_q),
    .sum_o   (sum_s),
    .cout_o  (cout_s),
    .c_msb_o (cmsb_s)
  );

  always_comb begin
    state_d = state_q;
    opd_d   = opd_q;
    wrk_d   = wrk_q;
    k_d     = k_q;
    cy_d    = cy_q;
    clr_d   = clr_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          opd_d   = sext(in_data_i);
          wrk_d   = in_clear_i ? '0 : acc_q;
          k_d     = '0;
          cy_d    = 1'b0;
          clr_d   = in_clear_i;
          state_d = ADD;
        end
      end
      ADD: begin
        wrk_d[k_q] = sum_s;
        cy_d       = cout_s;
        // Commit on the last slice so out_acc is already valid during DONE.
        if (k_q == K_LAST) begin
          acc_d   = wrk_d;
          ovf_d   = (cmsb_s ^ cout_s) | (ovf_q & ~clr_q);
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      opd_q   <= '0;
      wrk_q   <= '0;
      k_q     <= '0;
      cy_q    <= 1'b0;
      clr_q   <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opd_q   <= opd_d;
      wrk_q   <= wrk_d;
      k_q     <= k_d;
      cy_q    <= cy_d;
      clr_q   <= clr_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign out_acc_o   = acc_q;
  assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_mac_acc_seq.sv
// Directed bench for mac_acc_seq: hand-computed sums, handshake timing,
// sticky overflow and mid-operation reset.
module tb_mac_acc_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_clear;
  logic [31:0] in_data;
  logic        in_ready, out_valid, busy, ovf;
  logic [35:0] out_acc;

  int ncmp = 0;
  int nmis = 0;
  int cyc  = 0;

  mac_acc_seq dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_clear_i  (in_clear),
    .out_valid_o (out_valid),
    .out_acc_o   (out_acc),
    .busy_o      (busy),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nmis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One op: wait for ready, handshake, then watch 8 cycles for ready-low and the result pulse.
  task automatic op(input logic [31:0] d, input logic c, output logic [35:0] acc,
                    output logic ov, output int nlo, output int nv);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_op", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_clear = c;
    @(posedge clk);
    #1 in_valid = 1'b0;
    nlo = 0;
    nv  = 0;
    acc = 'x;
    ov  = 1'bx;
    repeat (8) begin
      @(negedge clk);
      if (!in_ready) nlo++;
      if (out_valid) begin
        nv++;
        acc = out_acc;
        ov  = ovf;
      end
    end
  endtask

  initial begin
    logic [35:0] acc;
    logic        ov;
    int          nlo, nv, w, nvs;
    int          t[4];
    logic [31:0] dat[4];

    rst = 1'b1; in_valid = 1'b0; in_clear = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_acc", {28'd0, out_acc}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);

    // 1: single clear op
    op(32'd5, 1'b1, acc, ov, nlo, nv);
    chk("t1_ready_low_cycles", 64'(nlo), 64'd7);
    chk("t1_valid_pulses", 64'(nv), 64'd1);
    chk("t1_acc", {28'd0, acc}, 64'd5);
    chk("t1_ovf", {63'd0, ov}, 64'd0);

    // 2: carry across slice 4 -> 5
    op(32'h7FFF_FFFF, 1'b1, acc, ov, nlo, nv);
    op(32'h0000_0001, 1'b0, acc, ov, nlo, nv);
    chk("t2_acc", {28'd0, acc}, 64'h0_8000_0000);

    // 3: signed values
    op(32'hFFFF_FFFD, 1'b1, acc, ov, nlo, nv);
    chk("t3_neg3", {28'd0, acc}, 64'h0000_000F_FFFF_FFFD);
    op(32'h0000_0001, 1'b0, acc, ov, nlo, nv);
    chk("t3_neg2", {28'd0, acc}, 64'h0000_000F_FFFF_FFFE);
    op(32'h0000_0007, 1'b1, acc, ov, nlo, nv);
    chk("t3_clear7", {28'd0, acc}, 64'd7);

    // 4: overflow, sticky, cleared by clear op
    op(32'h7FFF_FFFF, 1'b1, acc, ov, nlo, nv);
    for (int i = 0; i < 15; i++) op(32'h7FFF_FFFF, 1'b0, acc, ov, nlo, nv);
    chk("t4_acc16", {28'd0, acc}, 64'd34359738352);
    chk("t4_ovf16", {63'd0, ov}, 64'd0);
    op(32'h7FFF_FFFF, 1'b0, acc, ov, nlo, nv);
    chk("t4_acc_wrap", {28'd0, acc}, 64'h0000_0008_7FFF_FFEF);
    chk("t4_ovf_set", {63'd0, ov}, 64'd1);
    op(32'h7FFF_FFFF, 1'b0, acc, ov, nlo, nv);
    chk("t4_acc_after", {28'd0, acc}, 64'h0000_0008_FFFF_FFEE);
    chk("t4_ovf_sticky", {63'd0, ov}, 64'd1);
    op(32'h0, 1'b1, acc, ov, nlo, nv);
    chk("t4_clr_acc", {28'd0, acc}, 64'd0);
    chk("t4_clr_ovf", {63'd0, ov}, 64'd0);

    // 5: back-to-back with in_valid held high
    dat[0] = 32'd10; dat[1] = 32'd20; dat[2] = 32'd30; dat[3] = 32'd40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = dat[i];
      in_clear = (i == 0);
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      @(posedge clk);
      #1 t[i] = cyc;
    end
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) chk("t5_hs_spacing", 64'(t[i] - t[i-1]), 64'd8);
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 12) begin
      @(negedge clk);
      w++;
    end
    chk("t5_valid_seen", {63'd0, out_valid}, 64'd1);
    chk("t5_sum", {28'd0, out_acc}, 64'd100);

    // 6: reset during the third ADD cycle
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'd5; in_clear = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t6_busy_mid", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_acc_after_rst", {28'd0, out_acc}, 64'd0);
    chk("t6_ready_after_rst", {63'd0, in_ready}, 64'd1);
    nvs = 0;
    repeat (10) begin
      if (out_valid) nvs++;
      @(negedge clk);
    end
    chk("t6_no_pulse", 64'(nvs), 64'd0);
    op(32'd9, 1'b0, acc, ov, nlo, nv);
    chk("t6_next_op", {28'd0, acc}, 64'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule
